// File: rtl/spi_flash_arbiter.sv
// Round-robin transaction arbiter sharing one SPI flash pad group between two hosts.
// Optional owner timeout built when SPI_FLASH_ARB_TIMEOUT_EN is defined.
module spi_flash_arbiter #(
  parameter int NumCs         = 2,
  parameter int IdleCycles    = 4,
  parameter int TimeoutCycles = 65536
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         req_i,
  output logic [1:0]         gnt_o,
  input  logic [1:0]         m_sck_i,
  input  logic [2*NumCs-1:0] m_csb_i,
  input  logic [7:0]         m_sd_i,
  input  logic [7:0]         m_sd_oe_i,
  output logic [7:0]         m_sd_o,
  output logic               spi_sck_o,
  output logic [NumCs-1:0]   spi_csb_o,
  output logic [3:0]         spi_sd_o,
  output logic [3:0]         spi_sd_oe_o,
  input  logic [3:0]         spi_sd_i,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int GapW = $clog2(IdleCycles + 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(IdleCycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            own_q, own_d;
  logic            last_q, last_d;
  logic [GapW-1:0] gap_q, gap_d;

  logic [NumCs-1:0] own_csb;
  logic             own_req;
  logic             cs_low;
  logic             win;
  logic             revoke;

  assign own_csb = own_q ? m_csb_i[2*NumCs-1:NumCs]
                         : m_csb_i[NumCs-1:0];
  assign own_req = own_q ? req_i[1] : req_i[0];
  assign cs_low  = ~&own_csb;
  // on a tie the requester that did not own the bus last wins
  assign win     = (req_i == 2'b11) ? ~last_q : req_i[1];

`ifdef SPI_FLASH_ARB_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tflag_q, tflag_d;

  assign revoke = (state_q == StGrant) && cs_low
                  && (tmo_q == TmoLast);

  always_comb begin
    tmo_d   = '0;
    tflag_d = tflag_q | revoke;
    if (state_q == StGrant && cs_low) begin
      tmo_d = (tmo_q == TmoMax) ? tmo_q
                                : tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      tflag_q <= tflag_d;
    end
  end

  assign timeout_o = tflag_q;
`else
  localparam logic TmoTie = 1'b0 & (TimeoutCycles > 0);

  assign revoke    = 1'b0;
  assign timeout_o = TmoTie;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    last_d  = last_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StGrant;
          own_d   = win;
          gnt_d   = win ? 2'b10 : 2'b01;
        end
      end
      StGrant: begin
        if (revoke || (!own_req && !cs_low)) begin
          state_d = StGap;
          gnt_d   = 2'b00;
          last_d  = own_q;
          gap_d   = GapLoad;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          if (|req_i) begin
            state_d = StGrant;
            own_d   = win;
            gnt_d   = win ? 2'b10 : 2'b01;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      own_q   <= own_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

  // pad mux follows the registered grant so reset idles the pads at once
  always_comb begin
    spi_sck_o   = 1'b0;
    spi_csb_o   = '1;
    spi_sd_o    = 4'h0;
    spi_sd_oe_o = 4'h0;
    m_sd_o      = 8'h00;
    unique case (1'b1)
      gnt_q[0]: begin
        spi_sck_o   = m_sck_i[0];
        spi_csb_o   = m_csb_i[NumCs-1:0];
        spi_sd_o    = m_sd_i[3:0];
        spi_sd_oe_o = m_sd_oe_i[3:0];
        m_sd_o[3:0] = spi_sd_i;
      end
      gnt_q[1]: begin
        spi_sck_o   = m_sck_i[1];
        spi_csb_o   = m_csb_i[2*NumCs-1:NumCs];
        spi_sd_o    = m_sd_i[7:4];
        spi_sd_oe_o = m_sd_oe_i[7:4];
        m_sd_o[7:4] = spi_sd_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter (NumCs=2, IdleCycles=4, TimeoutCycles=100).
module tb_spi_flash_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] sck;
  logic [3:0] csb;
  logic [7:0] sd;
  logic [7:0] oe;
  logic [7:0] msd;
  logic       psck;
  logic [1:0] pcsb;
  logic [3:0] psd;
  logic [3:0] poe;
  logic [3:0] pin;
  logic       busy;
  logic       tmo;

  int n_chk;
  int n_bad;

  spi_flash_arbiter #(
    .NumCs(2),
    .IdleCycles(4),
    .TimeoutCycles(100)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req),
    .gnt_o(gnt),
    .m_sck_i(sck),
    .m_csb_i(csb),
    .m_sd_i(sd),
    .m_sd_oe_i(oe),
    .m_sd_o(msd),
    .spi_sck_o(psck),
    .spi_csb_o(pcsb),
    .spi_sd_o(psd),
    .spi_sd_oe_o(poe),
    .spi_sd_i(pin),
    .busy_o(busy),
    .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pads_idle(input string tag);
    chk({tag, "_sck"}, 32'(psck), 32'h0);
    chk({tag, "_csb"}, 32'(pcsb), 32'h3);
    chk({tag, "_sd"}, 32'(psd), 32'h0);
    chk({tag, "_oe"}, 32'(poe), 32'h0);
    chk({tag, "_msd"}, 32'(msd), 32'h0);
  endtask

  logic [1:0] exp_gnt;
  logic [1:0] exp_csb;
  logic       exp_tmo;

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 2'b00;
    sck   = 2'b00;
    csb   = 4'hF;
    sd    = 8'h00;
    oe    = 8'h00;
    pin   = 4'h5;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tmo", 32'(tmo), 32'h0);
    pads_idle("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // tie after reset goes to requester 0
    tick();
    req = 2'b11;
    #1;
    chk("pre_gnt", 32'(gnt), 32'h0);
    tick();
    chk("tie_gnt", 32'(gnt), 32'h1);
    chk("tie_busy", 32'(busy), 32'h1);

    // owner 0 active, requester 1 tries to drive the pads
    sck = 2'b01;
    csb = 4'b0010;
    sd  = 8'hFA;
    oe  = 8'hFF;
    #1;
    chk("own_sck", 32'(psck), 32'h1);
    chk("own_csb", 32'(pcsb), 32'h2);
    chk("own_sd", 32'(psd), 32'hA);
    chk("own_oe", 32'(poe), 32'hF);
    chk("own_msd", 32'(msd), 32'h05);
    sck = 2'b10;
    oe  = 8'hF3;
    #1;
    chk("iso_sck", 32'(psck), 32'h0);
    chk("iso_oe", 32'(poe), 32'h3);

    // owner drops req with CS still low: grant must hold
    req = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_gnt", 32'(gnt), 32'h1);
    end
    csb = 4'b0011;
    oe  = 8'hF0;
    #1;
    chk("rel_pre", 32'(gnt), 32'h1);
    tick();
    chk("rel_gnt", 32'(gnt), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);
    pads_idle("gap");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_gnt", 32'(gnt), 32'h0);
      chk("gap_csb", 32'(pcsb), 32'h3);
    end
    tick();
    chk("rr_gnt", 32'(gnt), 32'h2);
    chk("rr_csb", 32'(pcsb), 32'h0);
    chk("rr_oe", 32'(poe), 32'hF);
    chk("rr_msd", 32'(msd), 32'h50);

    // owner 1 releases, then a request dropped in IDLE
    req = 2'b00;
    csb = 4'hF;
    oe  = 8'h00;
    tick();
    chk("rel1_gnt", 32'(gnt), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    req = 2'b01;
    #2;
    req = 2'b00;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h0);
    tick();
    chk("drop_gnt2", 32'(gnt), 32'h0);

    // single requester 0, then tie must go to requester 1
    req = 2'b01;
    tick();
    chk("single_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    chk("single_rel", 32'(gnt), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    req = 2'b11;
    tick();
    chk("tie2_gnt", 32'(gnt), 32'h2);
    csb = 4'b0011;
    oe  = 8'hF0;
    #2;
    chk("tie2_csb", 32'(pcsb), 32'h0);

    // asynchronous reset mid-transfer
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_csb", 32'(pcsb), 32'h3);
    chk("arst_oe", 32'(poe), 32'h0);
    csb = 4'hF;
    oe  = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_tie", 32'(gnt), 32'h1);

    // owner 0 holds CS low for 150 cycles
    req = 2'b01;
    csb = 4'b1110;
`ifdef SPI_FLASH_ARB_TIMEOUT_EN
    exp_gnt = 2'b00;
    exp_csb = 2'b11;
    exp_tmo = 1'b1;
`else
    exp_gnt = 2'b01;
    exp_csb = 2'b10;
    exp_tmo = 1'b0;
`endif
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (i == 99) chk("tmo_g99", 32'(gnt), 32'h1);
      if (i == 100) chk("tmo_g100", 32'(gnt), 32'(exp_gnt));
      if (i == 101) chk("tmo_csb", 32'(pcsb), 32'(exp_csb));
    end
    chk("tmo_g150", 32'(gnt), 32'h1);
    chk("tmo_flag", 32'(tmo), 32'(exp_tmo));
    req = 2'b00;
    csb = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    chk("tmo_sticky", 32'(tmo), 32'(exp_tmo));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Transaction-level arbiter sharing the single gr-heep SPI flash pin group between two SPI host requesters: requester 0 is the boot/flash-execute controller, requester 1 is a secondary host such as a test loader or DMA-driven SPI. It sits between the requesters' pad-side signals and the `spi_flash_*` pads. It grants ownership round-robin, holds the grant for whole chip-select transactions, and enforces a minimum idle gap between owners.

## Interface
- `NumCs`, default 2: chip-select lines per requester and on the pad side.
- `IdleCycles`, default 4, minimum 1: cycles the bus stays idle between two ownerships (flash tCSH).
- `TimeoutCycles`, default 65536: maximum cycles an owner may hold any CS low. Used only with the timeout feature.

Ports:
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  2  per-requester bus request.
- `gnt_o`  out  2  one-hot grant; 0 when no owner.
- `m_sck_i`  in  2  per-requester SCK.
- `m_csb_i`  in  2×NumCs  per-requester chip selects, active-low.
- `m_sd_i`  in  2×4  per-requester SD output data.
- `m_sd_oe_i`  in  2×4  per-requester SD output enables.
- `m_sd_o`  out  2×4  pad SD input returned to the owner; 0 for the non-owner.
- `spi_sck_o`  out  1  pad SCK.
- `spi_csb_o`  out  NumCs  pad chip selects.
- `spi_sd_o`  out  4  pad SD output data.
- `spi_sd_oe_o`  out  4  pad SD output enables.
- `spi_sd_i`  in  4  pad SD input.
- `busy_o`  out  1  high while an owner is granted.
- `timeout_o`  out  1  sticky timeout flag.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner k is registered.
  - GAP: idle-gap counter runs.
- IDLE → GRANT when any `req_i` bit is high.
  - On simultaneous requests, the requester that was not the last owner wins.
  - After reset, the last-owner pointer is 1, so requester 0 wins a tie.
- GRANT → GAP when the owner's `req_i` is low and all of the owner's `m_csb_i` bits are high.
  - If the owner drops `req_i` while any of its CS is low, the grant is held until all its CS are high. Transactions are never cut.
  - On leaving GRANT, the last-owner pointer is set to the owner.
- GAP counts `IdleCycles` cycles. On the last gap cycle:
  - pending request → GRANT, round-robin applied;
  - no request → IDLE.
- Pad mux is selected by the registered owner.
  - Owner present: pad outputs equal the owner's inputs, and `m_sd_o[k] = spi_sd_i`.
  - No owner (IDLE, GAP, reset): `spi_sck_o=0`, `spi_csb_o` all 1s, `spi_sd_o=0`, `spi_sd_oe_o=0`, `m_sd_o` all 0.
- Signals from the non-owner are ignored entirely.
- Width rules:
  - gap counter: $clog2(IdleCycles+1) bits, loaded with `IdleCycles-1`, counts down to 0.
  - timeout counter: $clog2(TimeoutCycles+1) bits, saturating.

## Timing
- Reset values of all state-holding outputs: `gnt_o=0`, `busy_o=0`, `timeout_o=0`. Pad outputs are at the idle values.
- An asynchronous reset mid-transaction forces the idle pad values immediately, independent of the clock.
- Grant latency: `req_i` sampled high in IDLE at edge N → `gnt_o` and pad mux switch after edge N. One cycle of latency.
- Release: release condition sampled at edge R → `gnt_o=0` after R.
  - With a request pending, the next `gnt_o` rises after edge R+IdleCycles.
  - The bus is therefore idle for exactly `IdleCycles` cycles.
- `busy_o` equals OR of `gnt_o`, and is registered.
- `req_i` may deassert before `gnt_o` is seen. A request that is dropped while still in IDLE is not granted.

## Configuration
- Macro: `SPI_FLASH_ARB_TIMEOUT_EN`.
- Defined:
  - The timeout counter counts GRANT cycles during which any owner CS is low, and clears when all owner CS are high.
  - On reaching `TimeoutCycles`, the grant is revoked: the FSM goes to GAP, the pad goes idle the next cycle, and `timeout_o` is set sticky until reset.
  - The revoked owner gets lowest priority in the next arbitration.
- Undefined: no counter is built, `timeout_o` is tied to 0, and the grant is held indefinitely.

## Test plan
- Single requester: `req_i=01` at cycle 10 → `gnt_o=01` at cycle 11; `m_sck_i[0]` toggles and `m_csb_i[0]=10` appear on the pads; `m_sd_o[1]` is 0 throughout.
- Tie after reset: `req_i=11` → `gnt_o=01`. After release with `IdleCycles=4` → `gnt_o=10` exactly 4 cycles after `gnt_o` fell; pads are idle during the gap.
- Held transaction: owner 0 drops `req_i` while `csb[0]=0` for 20 more cycles → grant holds; it releases the cycle after CS goes high.
- Non-owner isolation: requester 1 drives `csb=00` and `sd_oe=F` while requester 0 owns → pads show only requester 0's values.
- Reset mid-transfer: `rst_ni` low while granted → `spi_csb_o=11`, `spi_sd_oe_o=0`, and `gnt_o=0` asynchronously; after reset, a tie goes to requester 0.
- With `SPI_FLASH_ARB_TIMEOUT_EN` and `TimeoutCycles=100`: owner holds CS low for 150 cycles → grant revoked at cycle 100 and `timeout_o=1` sticky. Without the macro, the same stimulus keeps the grant and `timeout_o` stays 0.
